// File: rtl/sprite_fetch_sched_pkg.sv
// Shared constants, slot geometry and config FSM types for the sprite fetch scheduler.
package sprite_sched_pkg;
   localparam int NUM_SLOTS = 4;
   localparam int ADDR_W    = 17;
   localparam int CNT_W     = 10;

   typedef enum logic [1:0] {CFG_IDLE, CFG_PEND, CFG_COMMIT} cfg_state_t;

   typedef struct packed {
      logic             en;
      logic [CNT_W-1:0] x;
      logic [CNT_W-1:0] y;
   } slot_cfg_t;

   function automatic int slot_w(input int s);
      case (s)
         0:       return 200;
         1, 2:    return 80;
         default: return 210;
      endcase
   endfunction

   function automatic int slot_h(input int s);
      case (s)
         0:       return 90;
         1, 2:    return 80;
         default: return 40;
      endcase
   endfunction

   function automatic int slot_base(input int s);
      case (s)
         0:       return 0;
         1:       return 18000;
         2:       return 24400;
         default: return 30800;
      endcase
   endfunction
endpackage

// File: rtl/sprite_fetch_sched_if.sv
// Pixel/config bus between the video timing side and the sprite fetch scheduler.
interface sprite_fetch_sched_if;
   import sprite_sched_pkg::*;
   logic [CNT_W-1:0]  h_cnt;
   logic [CNT_W-1:0]  v_cnt;
   logic              valid;
   logic              frame_start;
   logic              cfg_we;
   logic [1:0]        cfg_sel;
   logic [CNT_W-1:0]  cfg_x;
   logic [CNT_W-1:0]  cfg_y;
   logic              cfg_en;
   logic [ADDR_W-1:0] pixel_addr;
   logic              addr_valid;
   logic [1:0]        spr_id;
   logic              cfg_busy;

   modport master (
      output h_cnt, v_cnt, valid, frame_start, cfg_we, cfg_sel, cfg_x, cfg_y, cfg_en,
      input  pixel_addr, addr_valid, spr_id, cfg_busy
   );
   modport slave (
      input  h_cnt, v_cnt, valid, frame_start, cfg_we, cfg_sel, cfg_x, cfg_y, cfg_en,
      output pixel_addr, addr_valid, spr_id, cfg_busy
   );
endinterface

// File: rtl/sprite_fetch_sched_slot_match.sv
// Per-slot window hit test and ROM address; TILE turns the slot into a scrolling full-screen tile.
module sprite_slot_match
   import sprite_sched_pkg::*;
#(
   parameter int W    = 80,
   parameter int H    = 80,
   parameter int BASE = 0,
   parameter bit TILE = 1'b0
) (
   input  logic [CNT_W-1:0]  h_cnt,
   input  logic [CNT_W-1:0]  v_cnt,
   input  logic              valid,
   input  slot_cfg_t         cfg,
   output logic              hit,
   output logic [ADDR_W-1:0] addr
);
   // 11-bit compares so x+W never wraps
   logic [10:0] h11, v11, x11, y11;
   assign h11 = {1'b0, h_cnt};
   assign v11 = {1'b0, v_cnt};
   assign x11 = {1'b0, cfg.x};
   assign y11 = {1'b0, cfg.y};

   if (TILE) begin : g_tile
      logic [10:0] hs, vs, hm, vm;
      assign hs   = h11 + x11;
      assign vs   = v11 + y11;
      assign hm   = hs % 11'(W);
      assign vm   = vs % 11'(H);
      assign hit  = cfg.en & valid;
      assign addr = ADDR_W'(BASE) + ADDR_W'(hm) + ADDR_W'(W) * ADDR_W'(vm);
   end else begin : g_win
      logic [10:0] dh, dv;
      assign dh   = h11 - x11;
      assign dv   = v11 - y11;
      assign hit  = cfg.en & valid &
                    (h11 >= x11) & (h11 < x11 + 11'(W)) &
                    (v11 >= y11) & (v11 < y11 + 11'(H));
      assign addr = ADDR_W'(BASE) + ADDR_W'(dh) + ADDR_W'(W) * ADDR_W'(dv);
   end
endmodule

// File: rtl/sprite_fetch_sched.sv
// Four-slot sprite ROM fetch scheduler: 2-stage match/arbitrate pipeline with shadowed config.
// Build option: SCHED_TILE_EN makes slot0 a scrolling full-screen tile.
module sprite_fetch_sched
   import sprite_sched_pkg::*;
(
   input logic                 clk,
   input logic                 rst_n,
   sprite_fetch_sched_if.slave bus
);
`ifdef SCHED_TILE_EN
   localparam bit TILE0 = 1'b1;
`else
   localparam bit TILE0 = 1'b0;
`endif

   cfg_state_t                        state;
   logic                              busy_q;
   slot_cfg_t [NUM_SLOTS-1:0]         shadow_q, active_q;

   // Writes land in the shadow on the same edge as any transition, so a write
   // coinciding with frame_start in PEND is included in the following copy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= CFG_IDLE;
         busy_q   <= 1'b0;
         shadow_q <= '0;
         active_q <= '0;
      end else begin
         if (bus.cfg_we)
            shadow_q[bus.cfg_sel] <= '{en: bus.cfg_en, x: bus.cfg_x, y: bus.cfg_y};
         case (state)
            CFG_IDLE: if (bus.cfg_we) begin
               state  <= CFG_PEND;
               busy_q <= 1'b1;
            end
            CFG_PEND: if (bus.frame_start) state <= CFG_COMMIT;
            CFG_COMMIT: begin
               active_q <= shadow_q;
               state    <= bus.cfg_we ? CFG_PEND : CFG_IDLE;
               busy_q   <= bus.cfg_we;
            end
            default: begin
               state  <= CFG_IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   logic [NUM_SLOTS-1:0]             hit, hit_q;
   logic [NUM_SLOTS-1:0][ADDR_W-1:0] addr, addr_q;

   for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
      sprite_slot_match #(
         .W    (slot_w(s)),
         .H    (slot_h(s)),
         .BASE (slot_base(s)),
         .TILE ((s == 0) ? TILE0 : 1'b0)
      ) u_match (
         .h_cnt (bus.h_cnt),
         .v_cnt (bus.v_cnt),
         .valid (bus.valid),
         .cfg   (active_q[s]),
         .hit   (hit[s]),
         .addr  (addr[s])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_q  <= '0;
         addr_q <= '0;
      end else begin
         hit_q  <= hit;
         addr_q <= addr;
      end
   end

   logic [ADDR_W-1:0] sel_addr;
   logic [1:0]        sel_id;
   logic              sel_vld;

   // Scan high to low so the lowest-index hit ends up selected
   always_comb begin
      sel_addr = '0;
      sel_id   = '0;
      sel_vld  = 1'b0;
      for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
         if (hit_q[s]) begin
            sel_addr = addr_q[s];
            sel_id   = 2'(s);
            sel_vld  = 1'b1;
         end
      end
   end

   logic [ADDR_W-1:0] pix_q;
   logic [1:0]        id_q;
   logic              vld_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_q <= '0;
         id_q  <= '0;
         vld_q <= 1'b0;
      end else begin
         pix_q <= sel_addr;
         id_q  <= sel_id;
         vld_q <= sel_vld;
      end
   end

   assign bus.pixel_addr = pix_q;
   assign bus.spr_id     = id_q;
   assign bus.addr_valid = vld_q;
   assign bus.cfg_busy   = busy_q;
endmodule

// File: tb/tb_sprite_fetch_sched.sv
// Directed bench for sprite_fetch_sched: window hits, priority, edges, shadow commit, tiling, reset.
module tb_sprite_fetch_sched;
   logic clk;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   sprite_fetch_sched_if bus();

   sprite_fetch_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cfg_write(input logic [1:0] sel, input logic [9:0] x, input logic [9:0] y,
                            input logic en);
      bus.cfg_we = 1'b1; bus.cfg_sel = sel; bus.cfg_x = x; bus.cfg_y = y; bus.cfg_en = en;
      @(posedge clk); #1;
      bus.cfg_we = 1'b0;
   endtask

   task automatic commit;
      bus.frame_start = 1'b1;
      @(posedge clk); #1;
      bus.frame_start = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic px(input logic [9:0] h, input logic [9:0] v);
      bus.h_cnt = h; bus.v_cnt = v; bus.valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      #1;
      n_tests++;
      if ({bus.addr_valid, bus.spr_id, bus.pixel_addr, bus.cfg_busy} !== 21'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got v=%b id=%0d addr=%0d busy=%b, expected all 0",
                  bus.addr_valid, bus.spr_id, bus.pixel_addr, bus.cfg_busy);
      end
      #20 rst_n = 1'b1;
      @(posedge clk); #1;
      px(10'd0, 10'd0);
      n_tests++;
      if (bus.addr_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_no_slots: addr_valid=%b expected 0", bus.addr_valid);
      end
      bus.frame_start = 1'b1;
      @(posedge clk); #1;
      bus.frame_start = 1'b0;
      @(posedge clk); #1;
      n_tests++;
      if (bus.cfg_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_frame_start: cfg_busy=%b expected 0", bus.cfg_busy);
      end
   endtask

   task automatic test_basic;
      cfg_write(2'd1, 10'd100, 10'd50, 1'b1);
      commit();
      px(10'd105, 10'd52);
      n_tests++;
      if ({bus.addr_valid, bus.spr_id, bus.pixel_addr} !== {1'b1, 2'd1, 17'd18165}) begin
         n_fail++;
         $display("FAIL basic_hit: got v=%b id=%0d addr=%0d, expected v=1 id=1 addr=18165",
                  bus.addr_valid, bus.spr_id, bus.pixel_addr);
      end
   endtask

   task automatic test_priority;
      cfg_write(2'd2, 10'd100, 10'd50, 1'b1);
      commit();
      px(10'd100, 10'd50);
      n_tests++;
      if ({bus.addr_valid, bus.spr_id, bus.pixel_addr} !== {1'b1, 2'd1, 17'd18000}) begin
         n_fail++;
         $display("FAIL priority: got v=%b id=%0d addr=%0d, expected v=1 id=1 addr=18000",
                  bus.addr_valid, bus.spr_id, bus.pixel_addr);
      end
      px(10'd180, 10'd50);
      n_tests++;
      if ({bus.addr_valid, bus.spr_id, bus.pixel_addr} !== 20'd0) begin
         n_fail++;
         $display("FAIL right_edge_miss: got v=%b id=%0d addr=%0d, expected all 0",
                  bus.addr_valid, bus.spr_id, bus.pixel_addr);
      end
      bus.h_cnt = 10'd105; bus.v_cnt = 10'd52; bus.valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if (bus.addr_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL valid_low: addr_valid=%b expected 0", bus.addr_valid);
      end
   endtask

   task automatic test_boundary;
      cfg_write(2'd3, 10'd0, 10'd0, 1'b1);
      commit();
      px(10'd210, 10'd0);
      n_tests++;
      if ({bus.addr_valid, bus.spr_id, bus.pixel_addr} !== 20'd0) begin
         n_fail++;
         $display("FAIL slot3_h210: got v=%b id=%0d addr=%0d, expected all 0",
                  bus.addr_valid, bus.spr_id, bus.pixel_addr);
      end
      px(10'd209, 10'd39);
      n_tests++;
      if ({bus.addr_valid, bus.spr_id, bus.pixel_addr} !== {1'b1, 2'd3, 17'd39199}) begin
         n_fail++;
         $display("FAIL slot3_corner: got v=%b id=%0d addr=%0d, expected v=1 id=3 addr=39199",
                  bus.addr_valid, bus.spr_id, bus.pixel_addr);
      end
      px(10'd0, 10'd0);
      n_tests++;
      if ({bus.addr_valid, bus.spr_id, bus.pixel_addr} !== {1'b1, 2'd3, 17'd30800}) begin
         n_fail++;
         $display("FAIL slot3_origin: got v=%b id=%0d addr=%0d, expected v=1 id=3 addr=30800",
                  bus.addr_valid, bus.spr_id, bus.pixel_addr);
      end
      px(10'd0, 10'd40);
      n_tests++;
      if (bus.addr_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL slot3_v40: addr_valid=%b expected 0", bus.addr_valid);
      end
   endtask

   task automatic test_shadow;
      cfg_write(2'd1, 10'd300, 10'd200, 1'b1);
      n_tests++;
      if (bus.cfg_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL pend_busy: cfg_busy=%b expected 1", bus.cfg_busy);
      end
      px(10'd105, 10'd52);
      n_tests++;
      if ({bus.addr_valid, bus.spr_id, bus.pixel_addr} !== {1'b1, 2'd1, 17'd18165}) begin
         n_fail++;
         $display("FAIL shadow_hidden: got v=%b id=%0d addr=%0d, expected v=1 id=1 addr=18165",
                  bus.addr_valid, bus.spr_id, bus.pixel_addr);
      end
      bus.frame_start = 1'b1;
      @(posedge clk); #1;
      bus.frame_start = 1'b0;
      n_tests++;
      if (bus.cfg_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL commit_busy: cfg_busy=%b expected 1", bus.cfg_busy);
      end
      @(posedge clk); #1;
      n_tests++;
      if (bus.cfg_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL commit_done: cfg_busy=%b expected 0", bus.cfg_busy);
      end
      px(10'd305, 10'd202);
      n_tests++;
      if ({bus.addr_valid, bus.spr_id, bus.pixel_addr} !== {1'b1, 2'd1, 17'd18165}) begin
         n_fail++;
         $display("FAIL moved_hit: got v=%b id=%0d addr=%0d, expected v=1 id=1 addr=18165",
                  bus.addr_valid, bus.spr_id, bus.pixel_addr);
      end
      px(10'd105, 10'd52);
      n_tests++;
      if ({bus.addr_valid, bus.spr_id, bus.pixel_addr} !== {1'b1, 2'd2, 17'd24565}) begin
         n_fail++;
         $display("FAIL old_pos_slot2: got v=%b id=%0d addr=%0d, expected v=1 id=2 addr=24565",
                  bus.addr_valid, bus.spr_id, bus.pixel_addr);
      end
   endtask

   task automatic test_overlap;
      cfg_write(2'd2, 10'd500, 10'd400, 1'b1);
      // write coinciding with frame_start in PEND must be part of the commit
      bus.cfg_we = 1'b1; bus.cfg_sel = 2'd2; bus.cfg_x = 10'd600; bus.cfg_y = 10'd400;
      bus.cfg_en = 1'b1; bus.frame_start = 1'b1;
      @(posedge clk); #1;
      bus.frame_start = 1'b0;
      bus.cfg_sel = 2'd1; bus.cfg_x = 10'd700; bus.cfg_y = 10'd600;
      @(posedge clk); #1;
      bus.cfg_we = 1'b0;
      n_tests++;
      if (bus.cfg_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL commit_write_pend: cfg_busy=%b expected 1", bus.cfg_busy);
      end
      px(10'd605, 10'd402);
      n_tests++;
      if ({bus.addr_valid, bus.spr_id, bus.pixel_addr} !== {1'b1, 2'd2, 17'd24565}) begin
         n_fail++;
         $display("FAIL coincident_write: got v=%b id=%0d addr=%0d, expected v=1 id=2 addr=24565",
                  bus.addr_valid, bus.spr_id, bus.pixel_addr);
      end
      px(10'd705, 10'd602);
      n_tests++;
      if (bus.addr_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL commit_write_hidden: addr_valid=%b expected 0", bus.addr_valid);
      end
      commit();
      px(10'd705, 10'd602);
      n_tests++;
      if ({bus.addr_valid, bus.spr_id, bus.pixel_addr} !== {1'b1, 2'd1, 17'd18165}) begin
         n_fail++;
         $display("FAIL commit_write_applied: got v=%b id=%0d addr=%0d, expected v=1 id=1 addr=18165",
                  bus.addr_valid, bus.spr_id, bus.pixel_addr);
      end
   endtask

   task automatic test_tile;
      cfg_write(2'd0, 10'd180, 10'd25, 1'b1);
      commit();
`ifdef SCHED_TILE_EN
      px(10'd30, 10'd10);
      n_tests++;
      if ({bus.addr_valid, bus.spr_id, bus.pixel_addr} !== {1'b1, 2'd0, 17'd7010}) begin
         n_fail++;
         $display("FAIL tile_scroll: got v=%b id=%0d addr=%0d, expected v=1 id=0 addr=7010",
                  bus.addr_valid, bus.spr_id, bus.pixel_addr);
      end
      px(10'd0, 10'd0);
      n_tests++;
      if ({bus.addr_valid, bus.spr_id, bus.pixel_addr} !== {1'b1, 2'd0, 17'd5180}) begin
         n_fail++;
         $display("FAIL tile_origin: got v=%b id=%0d addr=%0d, expected v=1 id=0 addr=5180",
                  bus.addr_valid, bus.spr_id, bus.pixel_addr);
      end
`else
      px(10'd180, 10'd25);
      n_tests++;
      if ({bus.addr_valid, bus.spr_id, bus.pixel_addr} !== {1'b1, 2'd0, 17'd0}) begin
         n_fail++;
         $display("FAIL slot0_origin: got v=%b id=%0d addr=%0d, expected v=1 id=0 addr=0",
                  bus.addr_valid, bus.spr_id, bus.pixel_addr);
      end
      px(10'd30, 10'd10);
      n_tests++;
      if ({bus.addr_valid, bus.spr_id, bus.pixel_addr} !== {1'b1, 2'd3, 17'd32930}) begin
         n_fail++;
         $display("FAIL slot0_outside: got v=%b id=%0d addr=%0d, expected v=1 id=3 addr=32930",
                  bus.addr_valid, bus.spr_id, bus.pixel_addr);
      end
`endif
   endtask

   task automatic test_reset_pend;
      cfg_write(2'd1, 10'd100, 10'd50, 1'b1);
      px(10'd305, 10'd202);
      #1 rst_n = 1'b0;
      #1;
      n_tests++;
      if ({bus.addr_valid, bus.spr_id, bus.pixel_addr, bus.cfg_busy} !== 21'd0) begin
         n_fail++;
         $display("FAIL async_reset: got v=%b id=%0d addr=%0d busy=%b, expected all 0",
                  bus.addr_valid, bus.spr_id, bus.pixel_addr, bus.cfg_busy);
      end
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      commit();
      n_tests++;
      if (bus.cfg_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_pend_busy: cfg_busy=%b expected 0", bus.cfg_busy);
      end
      px(10'd105, 10'd52);
      n_tests++;
      if (bus.addr_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_no_commit: addr_valid=%b id=%0d addr=%0d, expected 0",
                  bus.addr_valid, bus.spr_id, bus.pixel_addr);
      end
      px(10'd305, 10'd202);
      n_tests++;
      if (bus.addr_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_cleared_active: addr_valid=%b expected 0", bus.addr_valid);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      bus.h_cnt = '0; bus.v_cnt = '0; bus.valid = 1'b0; bus.frame_start = 1'b0;
      bus.cfg_we = 1'b0; bus.cfg_sel = '0; bus.cfg_x = '0; bus.cfg_y = '0; bus.cfg_en = 1'b0;
      test_reset();
      test_basic();
      test_priority();
      test_boundary();
      test_shadow();
      test_overlap();
      test_tile();
      test_reset_pend();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
